// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile: clk-oversampled SPI slave; command word (rd/wr + start addr) then auto-incrementing register file data words
module spi_slave_regfile #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             spi_sclk,
  input  logic                             spi_cs_n,
  input  logic                             spi_mosi,
  output logic                             spi_miso,
  output logic                             spi_miso_oe,
  output logic [(2**ADDR_W)*DATA_W-1:0]    regs_q,
  output logic                             wr_stb,
  output logic [ADDR_W-1:0]                wr_addr,
  output logic                             busy
);
  localparam int NUM_REGS = 2**ADDR_W;
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
  logic sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d, armed_q, armed_d, rd_q, rd_d;
  logic miso_q, miso_d, oe_q, oe_d, wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d, ptr_inc, cmd_ptr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-2:0] rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d, word, cmd_reg, next_reg;
  logic [NUM_REGS*DATA_W-1:0] regs_d;
  logic sclk_s, cs_s, mosi_s, rise, fall, sample_e, shift_e, cs_fall, cs_rise, done;
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign rise = sclk_s & ~sclk_prev_q;
  assign fall = ~sclk_s & sclk_prev_q;
  assign sample_e = (CPOL == CPHA) ? rise : fall;
  assign shift_e = (CPOL == CPHA) ? fall : rise;
  assign cs_fall = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise = cs_s & ~cs_prev_q;
  assign word = {rx_q, mosi_s};
  assign done = sample_e && cnt_q == CW'(DATA_W-1);
  assign cmd_ptr = word[ADDR_W-1:0];
  assign ptr_inc = ptr_q + 1'b1;
  assign cmd_reg = regs_q[cmd_ptr*DATA_W +: DATA_W];
  assign next_reg = regs_q[ptr_inc*DATA_W +: DATA_W];
  assign spi_miso = miso_q;
  assign spi_miso_oe = oe_q;
  assign wr_stb = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign busy = state_q != IDLE;
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    cs_sync_d = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_prev_d = sclk_s;
    cs_prev_d = cs_s;
    armed_d = armed_q | cs_s;
    oe_d = armed_q & ~cs_s;
    state_d = state_q;
    cnt_d = cnt_q;
    rx_d = rx_q;
    tx_d = tx_q;
    ptr_d = ptr_q;
    rd_d = rd_q;
    miso_d = miso_q;
    regs_d = regs_q;
    wr_stb_d = 1'b0;
    wr_addr_d = wr_addr_q;
    if (state_q == IDLE) begin
      miso_d = 1'b0;
      if (cs_fall) begin
        state_d = CMD;
        cnt_d = '0;
      end
    end else begin
      if (sample_e) begin
        rx_d = word[DATA_W-2:0];
        cnt_d = done ? '0 : cnt_q + 1'b1;
      end
      if (state_q == CMD && done) begin
        state_d = DATA;
        rd_d = word[DATA_W-1];
        ptr_d = cmd_ptr;
        tx_d = cmd_reg;
        miso_d = (!CPHA && word[DATA_W-1]) ? cmd_reg[DATA_W-1] : 1'b0;
      end
      if (state_q == DATA && rd_q && shift_e && (CPHA || cnt_q != '0)) begin
        tx_d = tx_q << 1;
        miso_d = CPHA ? tx_q[DATA_W-1] : tx_q[DATA_W-2];
      end
      if (state_q == DATA && done) begin
        ptr_d = ptr_inc;
        if (rd_q) begin
          tx_d = next_reg;
          miso_d = CPHA ? miso_q : next_reg[DATA_W-1];
        end else begin
          regs_d[ptr_q*DATA_W +: DATA_W] = word;
          wr_stb_d = 1'b1;
          wr_addr_d = ptr_q;
        end
      end
      if (cs_rise) begin
        state_d = IDLE;
        cnt_d = '0;
        miso_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sclk_sync_q <= '0;
      cs_sync_q <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q <= 1'b0;
      armed_q <= 1'b0;
      oe_q <= 1'b0;
      cnt_q <= '0;
      rx_q <= '0;
      tx_q <= '0;
      ptr_q <= '0;
      rd_q <= 1'b0;
      miso_q <= 1'b0;
      regs_q <= '0;
      wr_stb_q <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q <= cs_prev_d;
      armed_q <= armed_d;
      oe_q <= oe_d;
      cnt_q <= cnt_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
      ptr_q <= ptr_d;
      rd_q <= rd_d;
      miso_q <= miso_d;
      regs_q <= regs_d;
      wr_stb_q <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
    end
  end
endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb_spi_slave_regfile: vector table, directed corner sequences and random transactions against a register-array model
module tb_spi_slave_regfile;
  localparam int H = 60;
  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, mosi = 1'b0;
  logic [5:0] cs_n = '1;
  logic [5:0] miso_v, oe_v, stb_v, busy_v;
  logic [127:0] regs0, regs1;
  logic [3:0] wa0, wa1;
  logic [1023:0] regs_w [4];
  logic [5:0] wa_w [4];
  int checks = 0, errors = 0;
  int sel = 0, w = 8, cpol = 0, cpha = 0;
  logic [15:0] txw [8];
  logic [15:0] rxw [8];
  logic [15:0] mem [6][64];
  int wq [6][$];
  typedef struct { logic [7:0] cmd, d0, d1, e0, e1; } vec_t;
  vec_t tbl [10];
  always #5 clk = ~clk;
  spi_slave_regfile u0 (.clk(clk), .rst(rst), .spi_sclk(sclk), .spi_cs_n(cs_n[0]), .spi_mosi(mosi),
    .spi_miso(miso_v[0]), .spi_miso_oe(oe_v[0]), .regs_q(regs0), .wr_stb(stb_v[0]), .wr_addr(wa0), .busy(busy_v[0]));
  spi_slave_regfile #(.CPOL(1'b1), .CPHA(1'b1)) u1 (.clk(clk), .rst(rst), .spi_sclk(sclk), .spi_cs_n(cs_n[1]), .spi_mosi(mosi),
    .spi_miso(miso_v[1]), .spi_miso_oe(oe_v[1]), .regs_q(regs1), .wr_stb(stb_v[1]), .wr_addr(wa1), .busy(busy_v[1]));
  for (genvar m = 0; m < 4; m++) begin : g_w
    spi_slave_regfile #(.DATA_W(16), .ADDR_W(6), .CPOL(m >= 2), .CPHA(m % 2 == 1)) u (.clk(clk), .rst(rst),
      .spi_sclk(sclk), .spi_cs_n(cs_n[m+2]), .spi_mosi(mosi), .spi_miso(miso_v[m+2]), .spi_miso_oe(oe_v[m+2]),
      .regs_q(regs_w[m]), .wr_stb(stb_v[m+2]), .wr_addr(wa_w[m]), .busy(busy_v[m+2]));
  end
  always @(negedge clk) begin
    if (stb_v[0]) wq[0].push_back(int'(wa0));
    if (stb_v[1]) wq[1].push_back(int'(wa1));
    for (int k = 0; k < 4; k++) if (stb_v[k+2]) wq[k+2].push_back(int'(wa_w[k]));
  end
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic check_regs(input int s);
    logic [127:0] e;
    if (s < 2) begin
      e = '0;
      for (int i = 0; i < 16; i++) e[i*8 +: 8] = mem[s][i][7:0];
      chk($sformatf("regs_inst%0d", s), s == 0 ? regs0 : regs1, e);
    end else
      for (int i = 0; i < 64; i++) chk($sformatf("inst%0d_reg%0d", s, i), 128'(regs_w[s-2][i*16 +: 16]), 128'(mem[s][i]));
  endtask
  task automatic set_sel(input int s);
    sel = s;
    w = s < 2 ? 8 : 16;
    cpol = s == 0 ? 0 : s == 1 ? 1 : ((s - 2) >= 2 ? 1 : 0);
    cpha = s == 0 ? 0 : s == 1 ? 1 : (s - 2) % 2;
    sclk = cpol[0];
    repeat (4) @(posedge clk);
    #2;
  endtask
  // endm: 0 raise CS after the last bit, 1 leave CS low, 2 raise CS together with the last sample edge
  task automatic xfer(input int nb, input bit start, input int endm);
    for (int k = 0; k < 8; k++) rxw[k] = '0;
    if (start) begin
      cs_n[sel] = 1'b0;
      #H;
    end
    for (int i = 0; i < nb; i++) begin
      bit b;
      b = txw[i/w][w-1-i%w];
      if (cpha == 0) begin
        mosi = b;
        #H;
        rxw[i/w][w-1-i%w] = miso_v[sel];
        sclk = ~cpol[0];
        if (i == nb - 1 && endm == 2) cs_n[sel] = 1'b1;
        #H;
        sclk = cpol[0];
      end else begin
        sclk = ~cpol[0];
        mosi = b;
        #H;
        rxw[i/w][w-1-i%w] = miso_v[sel];
        sclk = cpol[0];
        if (i == nb - 1 && endm == 2) cs_n[sel] = 1'b1;
        #H;
      end
    end
    if (endm != 1) begin
      #H;
      cs_n[sel] = 1'b1;
      repeat (8) @(posedge clk);
      #2;
    end
  endtask
  task automatic txn(input bit rd, input int addr, input int n, input logic [15:0] ign);
    int nr;
    logic [15:0] mask;
    nr = w == 8 ? 16 : 64;
    mask = ((16'd1 << (w - 1)) - 16'd1) & ~16'(nr - 1);
    txw[0] = (16'(rd) << (w - 1)) | (ign & mask) | 16'(addr);
    if (rd) for (int k = 1; k <= n; k++) txw[k] = 16'($urandom) & ((16'd1 << (w - 1) << 1) - 16'd1);
    wq[sel].delete();
    xfer((n + 1) * w, 1'b1, 0);
    chk("cmd_phase_miso", rxw[0], 0);
    for (int k = 0; k < n; k++) begin
      int a;
      a = (addr + k) % nr;
      if (rd) chk($sformatf("rd_inst%0d_a%0d", sel, a), rxw[k+1], mem[sel][a]);
      else begin
        mem[sel][a] = txw[k+1];
        chk("wr_miso_zero", rxw[k+1], 0);
      end
    end
    chk("wr_stb_count", wq[sel].size(), rd ? 0 : n);
    if (!rd) for (int k = 0; k < n && k < wq[sel].size(); k++) chk("wr_addr_seq", wq[sel][k], (addr + k) % nr);
    check_regs(sel);
  endtask
  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0] = '{8'h03, 8'h5A, 8'hC3, 8'h00, 8'h00};
    tbl[1] = '{8'h83, 8'h00, 8'h00, 8'h5A, 8'hC3};
    tbl[2] = '{8'h8F, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[3] = '{8'h0E, 8'h11, 8'h22, 8'h00, 8'h00};
    tbl[4] = '{8'h8E, 8'hFF, 8'hFF, 8'h11, 8'h22};
    tbl[5] = '{8'h0F, 8'h33, 8'h44, 8'h00, 8'h00};
    tbl[6] = '{8'h8F, 8'h00, 8'h00, 8'h33, 8'h44};
    tbl[7] = '{8'h65, 8'hA5, 8'h5A, 8'h00, 8'h00};
    tbl[8] = '{8'hF5, 8'h00, 8'h00, 8'hA5, 8'h5A};
    tbl[9] = '{8'h82, 8'h00, 8'h00, 8'h00, 8'h5A};
    for (int s = 0; s < 6; s++) for (int i = 0; i < 64; i++) mem[s][i] = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_regs0", regs0, 0);
    chk("rst_regs1", regs1, 0);
    chk("rst_flags", {miso_v, oe_v, stb_v, busy_v}, 0);
    chk("rst_wr_addr", {wa0, wa1, wa_w[0], wa_w[1], wa_w[2], wa_w[3]}, 0);
    for (int s = 2; s < 6; s++) check_regs(s);
    rst = 1'b0;
    set_sel(0);
    chk("idle_oe", oe_v, 0);
    chk("idle_miso", miso_v, 0);
    for (int r = 0; r < 10; r++) begin
      txw[0] = 16'(tbl[r].cmd);
      txw[1] = 16'(tbl[r].d0);
      txw[2] = 16'(tbl[r].d1);
      wq[0].delete();
      xfer(24, 1'b1, 0);
      chk($sformatf("tbl%0d_cmd_miso", r), rxw[0], 0);
      chk($sformatf("tbl%0d_miso0", r), rxw[1], 16'(tbl[r].e0));
      chk($sformatf("tbl%0d_miso1", r), rxw[2], 16'(tbl[r].e1));
      chk($sformatf("tbl%0d_stb_cnt", r), wq[0].size(), tbl[r].cmd[7] ? 0 : 2);
      if (!tbl[r].cmd[7]) begin
        mem[0][tbl[r].cmd[3:0]] = 16'(tbl[r].d0);
        mem[0][4'(tbl[r].cmd[3:0] + 4'd1)] = 16'(tbl[r].d1);
        if (wq[0].size() == 2) chk($sformatf("tbl%0d_stb_addrs", r), {wq[0][0], wq[0][1]}, {32'(tbl[r].cmd[3:0]), 32'(4'(tbl[r].cmd[3:0] + 4'd1))});
      end
      check_regs(0);
    end
    set_sel(1);
    txw[1] = 16'h77;
    txw[2] = 16'h12;
    txn(1'b0, 15, 2, 16'h0);
    txn(1'b1, 15, 2, 16'h0);
    chk("mode3_wrap_bytes", {rxw[0], rxw[1], rxw[2]}, {16'h00, 16'h77, 16'h12});
    for (int s = 2; s < 6; s++) begin
      set_sel(s);
      txw[1] = 16'hBEEF;
      txn(1'b0, 63, 1, 16'h0);
      txn(1'b1, 63, 1, 16'h0);
      chk($sformatf("wide%0d_beef", s), {rxw[0], rxw[1], regs_w[s-2][1023:1008]}, {16'h0000, 16'hBEEF, 16'hBEEF});
    end
    set_sel(0);
    wq[0].delete();
    txw[0] = 16'h01;
    txw[1] = 16'hFF;
    xfer(13, 1'b1, 1);
    chk("abort_busy_mid", busy_v[0], 1);
    chk("active_oe", oe_v, 6'b000001);
    cs_n[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_busy_after", busy_v[0], 0);
    chk("abort_no_stb", wq[0].size(), 0);
    chk("abort_oe_idle", {oe_v[0], miso_v[0]}, 0);
    check_regs(0);
    set_sel(1);
    wq[1].delete();
    txw[0] = 16'h05;
    txw[1] = 16'h3C;
    xfer(16, 1'b1, 2);
    mem[1][5] = 16'h3C;
    chk("cs_rise_with_last_edge_stb", wq[1].size(), 1);
    chk("cs_rise_with_last_edge_busy", busy_v[1], 0);
    check_regs(1);
    set_sel(0);
    txw[0] = 16'h02;
    txw[1] = 16'hF0;
    xfer(12, 1'b1, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_regs0", regs0, 0);
    chk("rst_mid_flags", {miso_v[0], oe_v[0], stb_v[0], wa0, busy_v[0]}, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    for (int s = 0; s < 6; s++) for (int i = 0; i < 64; i++) mem[s][i] = '0;
    txw[0] = 16'h03;
    txw[1] = 16'h55;
    xfer(16, 1'b0, 1);
    #H;
    chk("post_rst_ignored_busy", busy_v[0], 0);
    chk("post_rst_ignored_oe", oe_v[0], 0);
    check_regs(0);
    check_regs(3);
    cs_n[0] = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    txw[1] = 16'hAA;
    txn(1'b0, 2, 1, 16'h0);
    chk("post_rst_reg2", regs0[23:16], 8'hAA);
    for (int t = 0; t < 30; t++) begin
      int s, nr, addr, n;
      bit rd;
      s = $urandom_range(0, 5);
      set_sel(s);
      nr = w == 8 ? 16 : 64;
      rd = 1'($urandom_range(0, 1));
      addr = $urandom_range(0, nr - 1);
      n = $urandom_range(1, 4);
      for (int k = 1; k <= n; k++) txw[k] = w == 8 ? 16'($urandom_range(0, 255)) : 16'($urandom_range(0, 65535));
      txn(rd, addr, n, 16'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
